// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types and constants for the motor PWM scheduler
package motor_pkg;

    localparam int THROTTLE_W = 8;
    localparam logic [THROTTLE_W-1:0] MOTOR_OFF_OFFSET = 8'hFF;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } motor_state_e;

endpackage

// File: rtl/motor_pwm_scheduler_slew.sv
// rtl/motor_pwm_scheduler_slew.sv - per-channel throttle step, slew limited when MOTOR_SLEW_LIMIT_EN is defined
module slew_limiter
    import motor_pkg::*;
#(
    parameter int SLEW_STEP = 4
) (
    input  logic [THROTTLE_W-1:0] applied,
    input  logic [THROTTLE_W-1:0] target,
    input  logic                  step_en,
    output logic [THROTTLE_W-1:0] next_applied
);

`ifdef MOTOR_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    localparam logic signed [THROTTLE_W:0] STEP = (THROTTLE_W + 1)'(SLEW_STEP);

    logic signed [THROTTLE_W:0] diff;
    logic [THROTTLE_W-1:0]      limited;

    // Move toward target by at most STEP; the 9-bit signed difference never wraps
    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, applied});
        if (diff > STEP) begin
            limited = applied + STEP[THROTTLE_W-1:0];
        end else if (diff < -STEP) begin
            limited = applied - STEP[THROTTLE_W-1:0];
        end else begin
            limited = target;
        end
        if (!step_en) begin
            next_applied = applied;
        end else if (SLEW_EN) begin
            next_applied = limited;
        end else begin
            next_applied = target;
        end
    end

endmodule

// File: rtl/motor_pwm_scheduler.sv
// rtl/motor_pwm_scheduler.sv - frame-aligned throttle commit, arming and watchdog for ESC PWM channels (option: MOTOR_SLEW_LIMIT_EN)
module motor_pwm_scheduler
    import motor_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ARM_FRAMES  = 64,
    parameter int WDOG_FRAMES = 32,
    parameter int SLEW_STEP   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [$clog2(NUM_CH)-1:0]    cmd_ch,
    input  logic [THROTTLE_W-1:0]        cmd_throttle,
    input  logic                         arm_req,
    input  logic                         disarm_req,
    output logic [NUM_CH*THROTTLE_W-1:0] offset_out,
    output logic                         frame_start,
    output logic [1:0]                   state_out,
    output logic                         failsafe
);

    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int WW = $clog2(WDOG_FRAMES + 1);

    motor_state_e          state;
    logic [7:0]            frame_cnt;
    logic [AW-1:0]         arm_cnt;
    logic [WW-1:0]         wdog_cnt;
    logic [THROTTLE_W-1:0] shadow       [NUM_CH];
    logic [THROTTLE_W-1:0] applied      [NUM_CH];
    logic [THROTTLE_W-1:0] target       [NUM_CH];
    logic [THROTTLE_W-1:0] next_applied [NUM_CH];
    logic                  boundary;
    logic                  cmd_fire;
    logic                  cmd_in_range;
    logic                  step_en;
    logic                  shadows_zero;
    logic                  next_zero;

    assign boundary     = (frame_cnt == 8'hFF);
    assign cmd_ready    = ~rst;
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign cmd_in_range = (int'(cmd_ch) < NUM_CH);
    assign step_en      = boundary && (state == ST_ARMED || state == ST_FAILSAFE);
    assign state_out    = state;

    // Free-running frame counter kept in lockstep with the generator counters
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            frame_cnt   <= frame_cnt + 8'd1;
            frame_start <= boundary;
        end
    end

    // Commit targets (zero in failsafe) and all-zero summaries for the FSM
    always_comb begin
        shadows_zero = 1'b1;
        next_zero    = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            target[i] = (state == ST_FAILSAFE) ? '0 : shadow[i];
            if (shadow[i] != '0) shadows_zero = 1'b0;
            if (next_applied[i] != '0) next_zero = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        slew_limiter #(
            .SLEW_STEP(SLEW_STEP)
        ) u_slew (
            .applied     (applied[g]),
            .target      (target[g]),
            .step_en     (step_en),
            .next_applied(next_applied[g])
        );
        // offset is the bitwise complement of throttle
        assign offset_out[g*THROTTLE_W +: THROTTLE_W] = applied[g] ^ MOTOR_OFF_OFFSET;
    end

    // Safety FSM with shadow/applied registers; disarm overrides everything immediately
    always_ff @(posedge clk) begin
        if (rst || disarm_req) begin
            state    <= ST_DISARMED;
            arm_cnt  <= '0;
            wdog_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i]  <= '0;
                applied[i] <= '0;
            end
            if (rst) failsafe <= 1'b0;
        end else begin
            // A write on the boundary cycle lands after the commit reads the old shadow
            if (cmd_fire && cmd_in_range && state != ST_FAILSAFE) begin
                shadow[cmd_ch] <= cmd_throttle;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                applied[i] <= (state == ST_DISARMED || state == ST_ARMING) ? '0 : next_applied[i];
            end
            case (state)
                ST_DISARMED: begin
                    if (arm_req) begin
                        state    <= ST_ARMING;
                        failsafe <= 1'b0;
                        arm_cnt  <= '0;
                    end
                end
                ST_ARMING: begin
                    if (!arm_req) begin
                        state <= ST_DISARMED;
                    end else if (boundary) begin
                        if (!shadows_zero) begin
                            arm_cnt <= '0;
                        end else begin
                            arm_cnt <= arm_cnt + AW'(1);
                            if (arm_cnt == AW'(ARM_FRAMES - 1)) begin
                                state    <= ST_ARMED;
                                wdog_cnt <= '0;
                            end
                        end
                    end
                end
                ST_ARMED: begin
                    if (cmd_fire) begin
                        wdog_cnt <= '0;
                    end else if (boundary) begin
                        wdog_cnt <= wdog_cnt + WW'(1);
                        if (wdog_cnt == WW'(WDOG_FRAMES - 1)) begin
                            state    <= ST_FAILSAFE;
                            failsafe <= 1'b1;
                        end
                    end
                end
                ST_FAILSAFE: begin
                    if (boundary && next_zero) state <= ST_DISARMED;
                end
                default: state <= ST_DISARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_pwm_scheduler.sv
// tb/tb_motor_pwm_scheduler.sv - scoreboard bench for motor_pwm_scheduler
module tb_motor_pwm_scheduler;

    localparam int NUM_CH      = 4;
    localparam int ARM_FRAMES  = 64;
    localparam int WDOG_FRAMES = 32;
    localparam int SLEW_STEP   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ch = 2'd0;
    logic [7:0]  cmd_throttle = 8'd0;
    logic        arm_req = 1'b0;
    logic        disarm_req = 1'b0;
    logic [31:0] offset_out;
    logic        frame_start;
    logic [1:0]  state_out;
    logic        failsafe;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] off;
        logic [1:0]  st;
        logic        fs;
    } sb_t;
    sb_t sb_q[$];

    logic [7:0] m_shadow  [NUM_CH];
    logic [7:0] m_applied [NUM_CH];
    int         m_state = 0;
    int         m_wdog = 0;
    logic       m_fs = 1'b0;

    always #5 clk = ~clk;

    motor_pwm_scheduler #(
        .NUM_CH     (NUM_CH),
        .ARM_FRAMES (ARM_FRAMES),
        .WDOG_FRAMES(WDOG_FRAMES),
        .SLEW_STEP  (SLEW_STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_throttle(cmd_throttle),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .offset_out  (offset_out),
        .frame_start (frame_start),
        .state_out   (state_out),
        .failsafe    (failsafe)
    );

    function automatic logic [7:0] step(input logic [7:0] a, input logic [7:0] t);
`ifdef MOTOR_SLEW_LIMIT_EN
        int d;
        d = int'(t) - int'(a);
        if (d > SLEW_STEP) return a + 8'(SLEW_STEP);
        if (d < -SLEW_STEP) return a - 8'(SLEW_STEP);
        return t;
`else
        if (a == t) return a;
        return t;
`endif
    endfunction

    function automatic logic [31:0] model_off();
        logic [31:0] v;
        for (int i = 0; i < NUM_CH; i++) v[8*i +: 8] = ~m_applied[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i]  = 8'd0;
            m_applied[i] = 8'd0;
        end
        m_state = 0;
        m_wdog  = 0;
    endtask

    task automatic model_boundary();
        sb_t e;
        bit  all0;
        if (m_state == 2) begin
            for (int i = 0; i < NUM_CH; i++) m_applied[i] = step(m_applied[i], m_shadow[i]);
            m_wdog++;
            if (m_wdog == WDOG_FRAMES) begin
                m_state = 3;
                m_fs    = 1'b1;
            end
        end else if (m_state == 3) begin
            all0 = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_applied[i] = step(m_applied[i], 8'd0);
                if (m_applied[i] != 8'd0) all0 = 1'b0;
            end
            if (all0) m_state = 0;
        end
        e.off = model_off();
        e.st  = 2'(m_state);
        e.fs  = m_fs;
        sb_q.push_back(e);
    endtask

    task automatic send_cmd(input int ch, input logic [7:0] thr);
        cmd_valid    = 1'b1;
        cmd_ch       = ch[1:0];
        cmd_throttle = thr;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (m_state != 3 && ch < NUM_CH) m_shadow[ch] = thr;
        m_wdog = 0;
    endtask

    task automatic wait_boundary(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 300);
        ok = frame_start;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL boundary_timeout: frame_start=%0b after %0d cycles, required 1", frame_start, n);
        end
    endtask

    task automatic check_frames(input string tag);
        sb_t e;
        bit  ok;
        while (sb_q.size() > 0) begin
            wait_boundary(ok);
            e = sb_q.pop_front();
            checks++;
            if (offset_out !== e.off) begin
                errors++;
                $display("FAIL %s_offset: got %h required %h", tag, offset_out, e.off);
            end
            checks++;
            if (state_out !== e.st) begin
                errors++;
                $display("FAIL %s_state: got %0d required %0d", tag, state_out, e.st);
            end
            checks++;
            if (failsafe !== e.fs) begin
                errors++;
                $display("FAIL %s_failsafe: got %0b required %0b", tag, failsafe, e.fs);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 0", cmd_ready); end
        checks++;
        if (offset_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_offset: got %h required ffffffff", offset_out); end
        checks++;
        if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_out); end
        checks++;
        if (frame_start !== 1'b0 || failsafe !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got fs=%0b failsafe=%0b required 0 0", frame_start, failsafe);
        end
        rst = 1'b0;
        model_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 300);
        checks++;
        if (n != 256) begin errors++; $display("FAIL reset_first_frame: got %0d cycles required 256", n); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0b required 1", cmd_ready); end
    endtask

    task automatic test_arming();
        bit ok;
        arm_req = 1'b1;
        @(negedge clk);
        checks++;
        if (state_out !== 2'd1) begin errors++; $display("FAIL arming_enter: got %0d required 1", state_out); end
        for (int i = 0; i < 30; i++) wait_boundary(ok);
        repeat (20) @(negedge clk);
        send_cmd(1, 8'd10);
        wait_boundary(ok);
        checks++;
        if (state_out !== 2'd1) begin errors++; $display("FAIL arming_nonzero: got %0d required 1", state_out); end
        repeat (20) @(negedge clk);
        send_cmd(1, 8'd0);
        for (int i = 0; i < ARM_FRAMES - 1; i++) wait_boundary(ok);
        checks++;
        if (state_out !== 2'd1) begin errors++; $display("FAIL arming_restart: got %0d required 1", state_out); end
        checks++;
        if (offset_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL arming_offset: got %h required ffffffff", offset_out); end
        wait_boundary(ok);
        checks++;
        if (state_out !== 2'd2) begin errors++; $display("FAIL arming_done: got %0d required 2", state_out); end
        m_state = 2;
        m_wdog  = 0;
    endtask

    task automatic test_slew_up();
        int guard;
        repeat (20) @(negedge clk);
        send_cmd(0, 8'd100);
        checks++;
        if (offset_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL slew_before_boundary: got %h required ffffffff", offset_out); end
        guard = 0;
        while (m_applied[0] != 8'd100 && guard < 100) begin
            model_boundary();
            guard++;
        end
        check_frames("slew");
        checks++;
        if (offset_out[7:0] !== 8'd155) begin errors++; $display("FAIL slew_final: got %0d required 155", offset_out[7:0]); end
    endtask

    task automatic test_collision();
        sb_t e;
        repeat (255) @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_ch       = 2'd2;
        cmd_throttle = 8'd50;
        model_boundary();
        m_shadow[2] = 8'd50;
        m_wdog      = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL collision_align: got %0b required 1", frame_start); end
        e = sb_q.pop_front();
        checks++;
        if (offset_out !== e.off) begin errors++; $display("FAIL collision_same_boundary: got %h required %h", offset_out, e.off); end
        model_boundary();
        check_frames("collision_next");
    endtask

    task automatic test_back_to_back();
        repeat (10) @(negedge clk);
        send_cmd(1, 8'd7);
        send_cmd(3, 8'd200);
        send_cmd(1, 8'd30);
        model_boundary();
        model_boundary();
        check_frames("b2b");
    endtask

    task automatic test_disarm();
        for (int i = 0; i < NUM_CH; i++) send_cmd(i, 8'd200);
        model_boundary();
        model_boundary();
        check_frames("disarm_setup");
        repeat (100) @(negedge clk);
        checks++;
        if (offset_out !== model_off()) begin errors++; $display("FAIL disarm_pre: got %h required %h", offset_out, model_off()); end
        disarm_req = 1'b1;
        arm_req    = 1'b0;
        @(negedge clk);
        disarm_req = 1'b0;
        checks++;
        if (offset_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL disarm_offset: got %h required ffffffff", offset_out); end
        checks++;
        if (state_out !== 2'd0) begin errors++; $display("FAIL disarm_state: got %0d required 0", state_out); end
        model_reset();
    endtask

    task automatic test_watchdog();
        bit ok;
        int guard;
        repeat (10) @(negedge clk);
        arm_req = 1'b1;
        for (int i = 0; i < ARM_FRAMES; i++) wait_boundary(ok);
        checks++;
        if (state_out !== 2'd2) begin errors++; $display("FAIL rearm: got %0d required 2", state_out); end
        m_state = 2;
        m_wdog  = 0;
        arm_req = 1'b0;
        repeat (20) @(negedge clk);
        send_cmd(0, 8'd100);
        guard = 0;
        while (m_state != 0 && guard < 200) begin
            model_boundary();
            guard++;
        end
        check_frames("watchdog");
        repeat (5) @(negedge clk);
        checks++;
        if (failsafe !== 1'b1 || state_out !== 2'd0) begin
            errors++; $display("FAIL watchdog_sticky: got failsafe=%0b state=%0d required 1 0", failsafe, state_out);
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_slew_up();
        test_collision();
        test_back_to_back();
        test_disarm();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
